// File: rtl/pc_sequencer.sv
// Fetch PC sequencer: issues sequential fetch addresses and applies branch/jump
// redirects, deferring a redirect until an outstanding fetch request is accepted.
module pc_sequencer #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        stall,
   input  logic        br_valid,
   input  logic        br_take,
   input  logic [31:0] br_target,
   input  logic        jump_valid,
   input  logic [31:0] jump_target,
   output logic        fetch_valid,
   input  logic        fetch_ready,
   output logic [31:0] fetch_pc,
   output logic        flush,
   output logic        fetch_kill,
   output logic        misalign_err,
   output logic [15:0] redirect_cnt
);

   localparam int unsigned XLEN  = 32;
   localparam int unsigned CNT_W = 16;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      HOLD = 2'd2
   } state_t;

   state_t            state_q, state_d;
   logic [XLEN-1:0]   pc_q, pc_d;
   logic [XLEN-1:0]   tgt_q, tgt_d;
   logic              pend_q, pend_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;

   logic              redir_req;
   logic [XLEN-1:0]   redir_tgt;
   logic              redir_ok;
   logic              handshake;

   assign fetch_pc     = pc_q;
   assign redirect_cnt = cnt_q;

   // Redirect decode: jump has priority over a taken branch; only honoured once running.
   always_comb begin
      redir_tgt = jump_valid ? jump_target : br_target;
      redir_req = (state_q != IDLE) && ((br_valid && br_take) || jump_valid);
      redir_ok  = redir_req && (redir_tgt[1:0] == 2'b00);
   end

   // State register and architectural state, synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
         pc_q    <= RESET_PC;
         tgt_q   <= '0;
         pend_q  <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         tgt_q   <= tgt_d;
         pend_q  <= pend_d;
         cnt_q   <= cnt_d;
      end
   end

   // Next-state and output logic; fetch_valid depends only on state, pend_q and stall.
   always_comb begin
      state_d      = state_q;
      pc_d         = pc_q;
      tgt_d        = tgt_q;
      pend_d       = 1'b0;
      cnt_d        = cnt_q;
      fetch_valid  = 1'b0;
      flush        = 1'b0;
      fetch_kill   = 1'b0;
      misalign_err = redir_req && !redir_ok;
      handshake    = 1'b0;

      if (redir_ok && (cnt_q != '1)) begin
         cnt_d = cnt_q + CNT_W'(1);
      end

      case (state_q)
         IDLE: begin
            state_d = RUN;
         end
         RUN: begin
            fetch_valid = pend_q || !stall;
            handshake   = fetch_valid && fetch_ready;
            pend_d      = fetch_valid && !fetch_ready;
            if (redir_ok) begin
               flush = 1'b1;
               if (fetch_valid && !fetch_ready) begin
                  // Outstanding request must complete at its own address first.
                  tgt_d   = redir_tgt;
                  state_d = HOLD;
               end else begin
                  fetch_kill = handshake;
                  pc_d       = redir_tgt;
               end
            end else if (handshake) begin
               pc_d = pc_q + XLEN'(4);
            end
         end
         HOLD: begin
            fetch_valid = 1'b1;
            handshake   = fetch_ready;
            if (redir_ok) begin
               flush = 1'b1;
               tgt_d = redir_tgt;
            end
            if (handshake) begin
               fetch_kill = 1'b1;
               pc_d       = redir_ok ? redir_tgt : tgt_q;
               state_d    = RUN;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed vector table plus randomized
// stimulus checked against a behavioural model of the fetch sequencing rules.
module tb_pc_sequencer;

   logic        clk;
   logic        rst_n;
   logic        stall;
   logic        br_valid;
   logic        br_take;
   logic [31:0] br_target;
   logic        jump_valid;
   logic [31:0] jump_target;
   logic        fetch_valid;
   logic        fetch_ready;
   logic [31:0] fetch_pc;
   logic        flush;
   logic        fetch_kill;
   logic        misalign_err;
   logic [15:0] redirect_cnt;

   int checks = 0;
   int errors = 0;

   pc_sequencer #(.RESET_PC(32'h0000_0000)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .stall        (stall),
      .br_valid     (br_valid),
      .br_take      (br_take),
      .br_target    (br_target),
      .jump_valid   (jump_valid),
      .jump_target  (jump_target),
      .fetch_valid  (fetch_valid),
      .fetch_ready  (fetch_ready),
      .fetch_pc     (fetch_pc),
      .flush        (flush),
      .fetch_kill   (fetch_kill),
      .misalign_err (misalign_err),
      .redirect_cnt (redirect_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        rst;
      logic        stl;
      logic        bv;
      logic        bt;
      logic [31:0] btg;
      logic        jv;
      logic [31:0] jtg;
      logic        rdy;
      logic        e_fv;
      logic [31:0] e_pc;
      logic        e_fl;
      logic        e_kl;
      logic        e_me;
      logic [15:0] e_cnt;
   } vec_t;

   vec_t vq[$];

   function automatic vec_t mk(logic rst, logic stl, logic bv, logic bt, logic [31:0] btg,
                               logic jv, logic [31:0] jtg, logic rdy, logic e_fv,
                               logic [31:0] e_pc, logic e_fl, logic e_kl, logic e_me,
                               logic [15:0] e_cnt);
      vec_t v;
      v.rst = rst; v.stl = stl; v.bv = bv; v.bt = bt; v.btg = btg;
      v.jv = jv; v.jtg = jtg; v.rdy = rdy; v.e_fv = e_fv; v.e_pc = e_pc;
      v.e_fl = e_fl; v.e_kl = e_kl; v.e_me = e_me; v.e_cnt = e_cnt;
      return v;
   endfunction

   task automatic check(input string name, input int idx, input logic [31:0] act,
                        input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s @%0d: got 0x%08h, expected 0x%08h", name, idx, act, exp);
      end
   endtask

   task automatic drive(input logic rst, input logic stl, input logic bv, input logic bt,
                        input logic [31:0] btg, input logic jv, input logic [31:0] jtg,
                        input logic rdy);
      rst_n = rst; stall = stl; br_valid = bv; br_take = bt; br_target = btg;
      jump_valid = jv; jump_target = jtg; fetch_ready = rdy;
   endtask

   // Behavioural model: where the sequencer is and what it owes.
   bit          m_idle, m_hold, m_pend;
   logic [31:0] m_pc, m_tgt;
   int          m_cnt;

   task automatic model_reset();
      m_idle = 1; m_hold = 0; m_pend = 0; m_pc = 32'h0; m_tgt = 32'h0; m_cnt = 0;
   endtask

   initial begin
      drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
      repeat (2) @(posedge clk);
      #1;

      // Directed sequence: reset, stepping, redirects, HOLD, misalign, wrap, reset-in-HOLD.
      vq.push_back(mk(0,0,0,0,32'h0,0,32'h0,1, 0,32'h0,0,0,0,0));
      vq.push_back(mk(1,0,0,0,32'h0,0,32'h0,1, 0,32'h0,0,0,0,0));
      vq.push_back(mk(1,0,0,0,32'h0,0,32'h0,1, 1,32'h0,0,0,0,0));
      vq.push_back(mk(1,0,0,0,32'h0,0,32'h0,1, 1,32'h4,0,0,0,0));
      vq.push_back(mk(1,0,0,0,32'h0,0,32'h0,1, 1,32'h8,0,0,0,0));
      vq.push_back(mk(1,0,1,1,32'h100,0,32'h0,1, 1,32'hC,1,1,0,0));
      vq.push_back(mk(1,0,0,0,32'h0,0,32'h0,1, 1,32'h100,0,0,0,1));
      vq.push_back(mk(1,1,0,0,32'h0,0,32'h0,1, 0,32'h104,0,0,0,1));
      vq.push_back(mk(1,1,1,1,32'h10,0,32'h0,1, 0,32'h104,1,0,0,1));
      vq.push_back(mk(1,0,0,0,32'h0,0,32'h0,1, 1,32'h10,0,0,0,2));
      vq.push_back(mk(1,0,0,0,32'h0,0,32'h0,1, 1,32'h14,0,0,0,2));
      vq.push_back(mk(1,0,0,0,32'h0,0,32'h0,1, 1,32'h18,0,0,0,2));
      vq.push_back(mk(1,0,0,0,32'h0,0,32'h0,1, 1,32'h1C,0,0,0,2));
      vq.push_back(mk(1,0,0,0,32'h0,0,32'h0,0, 1,32'h20,0,0,0,2));
      vq.push_back(mk(1,1,0,0,32'h0,1,32'h200,0, 1,32'h20,1,0,0,2));
      vq.push_back(mk(1,0,1,1,32'h300,0,32'h0,0, 1,32'h20,1,0,0,3));
      vq.push_back(mk(1,0,0,0,32'h0,0,32'h0,0, 1,32'h20,0,0,0,4));
      vq.push_back(mk(1,0,0,0,32'h0,0,32'h0,1, 1,32'h20,0,1,0,4));
      vq.push_back(mk(1,0,0,0,32'h0,1,32'h402,1, 1,32'h300,0,0,1,4));
      vq.push_back(mk(1,0,0,0,32'h0,1,32'hFFFF_FFFC,1, 1,32'h304,1,1,0,4));
      vq.push_back(mk(1,0,0,0,32'h0,0,32'h0,1, 1,32'hFFFF_FFFC,0,0,0,5));
      vq.push_back(mk(1,0,0,0,32'h0,0,32'h0,1, 1,32'h0,0,0,0,5));
      vq.push_back(mk(1,0,0,0,32'h0,0,32'h0,0, 1,32'h4,0,0,0,5));
      vq.push_back(mk(1,0,0,0,32'h0,1,32'h40,0, 1,32'h4,1,0,0,5));
      vq.push_back(mk(0,0,0,0,32'h0,0,32'h0,0, 1,32'h4,0,0,0,6));
      vq.push_back(mk(0,0,0,0,32'h0,0,32'h0,1, 0,32'h0,0,0,0,0));
      vq.push_back(mk(1,0,0,0,32'h0,1,32'h80,1, 0,32'h0,0,0,0,0));
      vq.push_back(mk(1,0,0,0,32'h0,0,32'h0,1, 1,32'h0,0,0,0,0));
      vq.push_back(mk(1,0,1,1,32'h500,1,32'h600,1, 1,32'h4,1,1,0,0));
      vq.push_back(mk(1,0,0,0,32'h0,0,32'h0,1, 1,32'h600,0,0,0,1));
      vq.push_back(mk(1,0,1,1,32'h700,1,32'h601,0, 1,32'h604,0,0,1,1));
      vq.push_back(mk(1,1,0,0,32'h0,0,32'h0,1, 1,32'h604,0,0,0,1));
      vq.push_back(mk(1,1,0,0,32'h0,0,32'h0,1, 0,32'h608,0,0,0,1));

      for (int i = 0; i < vq.size(); i++) begin
         drive(vq[i].rst, vq[i].stl, vq[i].bv, vq[i].bt, vq[i].btg, vq[i].jv, vq[i].jtg,
               vq[i].rdy);
         #4;
         check("dir_fetch_valid",  i, 32'(fetch_valid),  32'(vq[i].e_fv));
         check("dir_fetch_pc",     i, fetch_pc,          vq[i].e_pc);
         check("dir_flush",        i, 32'(flush),        32'(vq[i].e_fl));
         check("dir_fetch_kill",   i, 32'(fetch_kill),   32'(vq[i].e_kl));
         check("dir_misalign_err", i, 32'(misalign_err), 32'(vq[i].e_me));
         check("dir_redirect_cnt", i, 32'(redirect_cnt), 32'(vq[i].e_cnt));
         @(posedge clk);
         #1;
      end

      // Randomized phase against the behavioural model.
      drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
      @(posedge clk);
      #1;
      model_reset();
      for (int c = 0; c < 3000; c++) begin
         logic        r_rst, r_stl, r_bv, r_bt, r_jv, r_rdy;
         logic [31:0] r_btg, r_jtg, t;
         bit          redir, aligned, acc, fv, hs, e_kill;
         r_rst = ($urandom_range(99) >= 2);
         r_stl = ($urandom_range(99) < 30);
         r_bv  = ($urandom_range(99) < 15);
         r_bt  = ($urandom_range(1) == 1);
         r_jv  = ($urandom_range(99) < 10);
         r_rdy = ($urandom_range(99) < 65);
         r_btg = $urandom() & 32'hFFFF_FFFC;
         r_jtg = ($urandom_range(9) == 0) ? 32'hFFFF_FFF8 : ($urandom() & 32'hFFFF_FFFC);
         if ($urandom_range(4) == 0) r_btg[1:0] = 2'($urandom_range(3));
         if ($urandom_range(4) == 0) r_jtg[1:0] = 2'($urandom_range(3));
         drive(r_rst, r_stl, r_bv, r_bt, r_btg, r_jv, r_jtg, r_rdy);
         #4;
         t       = r_jv ? r_jtg : r_btg;
         redir   = !m_idle && ((r_bv && r_bt) || r_jv);
         aligned = (t % 4) == 0;
         acc     = redir && aligned;
         fv      = m_hold || (!m_idle && (m_pend || !r_stl));
         hs      = fv && r_rdy;
         e_kill  = hs && (m_hold || acc);
         check("rnd_fetch_valid",  c, 32'(fetch_valid),  32'(fv));
         check("rnd_fetch_pc",     c, fetch_pc,          m_pc);
         check("rnd_flush",        c, 32'(flush),        32'(acc));
         check("rnd_fetch_kill",   c, 32'(fetch_kill),   32'(e_kill));
         check("rnd_misalign_err", c, 32'(misalign_err), 32'(redir && !aligned));
         check("rnd_redirect_cnt", c, 32'(redirect_cnt), 32'(m_cnt));
         @(posedge clk);
         #1;
         if (!r_rst) begin
            model_reset();
         end else if (m_idle) begin
            m_idle = 0;
         end else begin
            if (m_hold) begin
               if (acc) m_tgt = t;
               if (hs) begin
                  m_pc   = m_tgt;
                  m_hold = 0;
               end
               m_pend = 0;
            end else begin
               if (acc) begin
                  if (fv && !r_rdy) begin
                     m_hold = 1;
                     m_tgt  = t;
                  end else begin
                     m_pc = t;
                  end
               end else if (hs) begin
                  m_pc = m_pc + 32'd4;
               end
               m_pend = fv && !r_rdy;
            end
            if (acc && m_cnt < 65535) m_cnt = m_cnt + 1;
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 The block SHALL have parameter RESET_PC, default 32'h0000_0000, giving the first fetch address after reset.
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1, reset that is synchronous and active-low.
REQ-004 The block SHALL have port stall, input, 1, decode-stage backpressure: issue no new fetch.
REQ-005 The block SHALL have port br_valid, input, 1, a conditional branch resolved in EX this cycle.
REQ-006 The block SHALL have port br_take, input, 1, the taken decision from the branch condition unit; qualified by br_valid.
REQ-007 The block SHALL have port br_target, input, 32, the branch target byte address.
REQ-008 The block SHALL have port jump_valid, input, 1, an unconditional jump (JAL/JALR) resolved in EX this cycle.
REQ-009 The block SHALL have port jump_target, input, 32, the jump target byte address.
REQ-010 The block SHALL have port fetch_valid, output, 1, fetch request valid.
REQ-011 The block SHALL have port fetch_ready, input, 1, the instruction memory accepts the request.
REQ-012 The block SHALL have port fetch_pc, output, 32, the fetch request address.
REQ-013 The block SHALL have port flush, output, 1, a one-cycle pulse that kills the IF/ID pipeline contents.
REQ-014 The block SHALL have port fetch_kill, output, 1, a one-cycle pulse marking the response to the request accepted this cycle as stale.
REQ-015 The block SHALL have port misalign_err, output, 1, a one-cycle pulse when a redirect target has bits [1:0] != 0.
REQ-016 The block SHALL have port redirect_cnt, output, 16, a saturating count of accepted redirects.

Function
REQ-017 The block SHALL implement states IDLE, RUN and HOLD; reset enters IDLE, and IDLE SHALL go to RUN unconditionally on the next cycle.
REQ-018 A redirect request SHALL be defined as (br_valid & br_take) | jump_valid; if both are set in the same cycle, jump_target SHALL win.
REQ-019 A redirect with target[1:0] != 0 SHALL be ignored (no PC change, no flush), and misalign_err SHALL pulse in that same cycle.
REQ-020 In IDLE, fetch_valid SHALL be 0; in RUN, fetch_valid SHALL be !stall unless a request is already pending.
REQ-021 A request is pending while fetch_valid=1 and fetch_ready=0; while pending, fetch_valid SHALL stay 1 and fetch_pc SHALL stay stable regardless of stall.
REQ-022 In RUN, on a handshake (fetch_valid & fetch_ready) with no redirect, fetch_pc SHALL become fetch_pc+4 on the next cycle, wrapping modulo 2^32 (32'hFFFF_FFFC -> 32'h0).
REQ-023 In RUN, a redirect with no request pending SHALL set fetch_pc to the target on the next cycle and pulse flush in the redirect cycle.
REQ-024 If that redirect cycle is also a handshake, the handshake SHALL be accepted, fetch_kill SHALL pulse, and the PC SHALL NOT increment.
REQ-025 In RUN, a redirect while a request is pending SHALL pulse flush, store the target, and move to HOLD.
REQ-026 In HOLD, fetch_pc and fetch_valid=1 SHALL be held; on the handshake, fetch_kill SHALL pulse, fetch_pc SHALL become the stored target on the next cycle, and the state SHALL return to RUN.
REQ-027 A new redirect in HOLD SHALL overwrite the stored target (newest wins) and pulse flush again.
REQ-028 If that new redirect coincides with the HOLD handshake, the new target SHALL be used.
REQ-029 redirect_cnt SHALL increment by 1 per accepted (aligned) redirect and saturate at 16'hFFFF.
REQ-030 flush, fetch_kill and misalign_err SHALL be asserted for exactly one cycle per causing event.
REQ-031 There SHALL be no combinational path from fetch_ready to fetch_valid or to fetch_pc.

Reset
REQ-032 While rst_n=0 at a clock edge: state=IDLE, fetch_pc=RESET_PC, fetch_valid=0, flush=0, fetch_kill=0, misalign_err=0, redirect_cnt=0, and the stored target SHALL be cleared.
REQ-033 Reset SHALL override any pending request or HOLD state; the first request after reset SHALL be RESET_PC, two cycles after rst_n rises.

Verification
REQ-034 The bench SHALL cover: reset release with fetch_ready=1 and no redirects -> fetch_pc sequence 0x0, 0x4, 0x8, ... one per cycle.
REQ-035 The bench SHALL cover: br_valid=1, br_take=1, br_target=0x100 with no request pending -> flush pulses 1 cycle, next fetch_pc=0x100, redirect_cnt=1.
REQ-036 The bench SHALL cover: fetch_ready=0 holding request 0x20, then jump to 0x200 followed by a branch to 0x300 while in HOLD -> fetch_pc stays 0x20 and flush pulses twice; when fetch_ready=1, fetch_kill pulses and next fetch_pc=0x300.
REQ-037 The bench SHALL cover: jump_valid=1 with jump_target=0x402 -> misalign_err pulses, fetch_pc unchanged, redirect_cnt unchanged.
REQ-038 The bench SHALL cover: fetch_pc=0xFFFF_FFFC with a handshake -> next fetch_pc=0x0; stall=1 with no pending request -> fetch_valid=0 and fetch_pc held.
REQ-039 The bench SHALL cover: rst_n=0 asserted while in HOLD -> all outputs return to their reset values next cycle, and fetch_pc=RESET_PC.
